// File: rtl/_alu_defs.sv
// Shared ALU definitions: datapath width, multiply
// sequencer state encodings, iteration and latency constants.
package _alu_defs;

  localparam int unsigned ALU_W = 6;

  // One ADD cycle per multiplier bit.
  localparam int unsigned MUL_ITER = 6;

  // Edges from accepted start to the done cycle.
  localparam int unsigned MUL_LAT_SIGNED   = 10;
  localparam int unsigned MUL_LAT_UNSIGNED = 7;

  localparam logic [2:0] MUL_LAST_ITER =
    3'(MUL_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_ADD   = 3'd3,
    S_NEG_R = 3'd4,
    S_DONE  = 3'd5
  } mul_state_e;

endpackage

// File: rtl/_6bit_ripple_adder.sv
// Shared ripple-carry adder/subtractor: sum_o = x_i + (sel_i ? ~y_i + 1 : y_i).
// Ports: x_i, y_i operands; sel_i subtract; sum_o result; c_o carry out.
module _6bit_ripple_adder
  import _alu_defs::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sel_i,
  output logic [W-1:0] sum_o,
  output logic         c_o
);

  logic [W:0]   c;
  logic [W-1:0] yx;

  // Subtract as x + ~y + 1: invert y, seed carry with sel.
  assign c[0] = sel_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign yx[i]    = y_i[i] ^ sel_i;
    assign sum_o[i] = x_i[i] ^ yx[i] ^ c[i];
    assign c[i+1]   = (x_i[i] & yx[i])
                    | (c[i] & (x_i[i] ^ yx[i]));
  end

  assign c_o = c[W];

endmodule

// File: rtl/_mul_sequencer.sv
// Shift-add multiplier FSM on one shared 6-bit ripple adder.
// Ports: clk, reset (sync, high), start, a, b -> y, ovf, busy, done.
// MUL_SEQ_SIGNED_EN: signed operands with NEG_A/NEG_B/NEG_R steps.
module _mul_sequencer
  import _alu_defs::*;
#(
  parameter int unsigned N_BITS = ALU_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] y,
  output logic              ovf,
  output logic              busy,
  output logic              done
);

  mul_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [N_BITS-1:0] mcand_q;
  logic [N_BITS-1:0] mplier_q;
  logic [N_BITS-1:0] acc_hi_q;

`ifdef MUL_SEQ_SIGNED_EN
  logic [N_BITS-1:0]   a_q;
  logic [N_BITS-1:0]   b_q;
  logic                sign_q;
  logic [2*N_BITS-1:0] mag;
  logic                ovf_d;
`endif

  logic [N_BITS-1:0] add_x;
  logic [N_BITS-1:0] add_y;
  logic [N_BITS-1:0] add_s;
  logic              add_sel;
  logic              add_c;

  // Adder operand mux. ADD adds zero when the
  // multiplier LSB is clear, so carry is 0 then.
  always_comb begin
    add_x   = acc_hi_q;
    add_y   = mplier_q[0] ? mcand_q : '0;
    add_sel = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
    unique case (state_q)
      S_NEG_A: begin
        add_x   = '0;
        add_y   = a_q;
        add_sel = 1'b1;
      end
      S_NEG_B: begin
        add_x   = '0;
        add_y   = b_q;
        add_sel = 1'b1;
      end
      S_NEG_R: begin
        add_x   = '0;
        add_y   = mplier_q;
        add_sel = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  _6bit_ripple_adder #(
    .W(N_BITS)
  ) u_add (
    .x_i  (add_x),
    .y_i  (add_y),
    .sel_i(add_sel),
    .sum_o(add_s),
    .c_o  (add_c)
  );

`ifdef MUL_SEQ_SIGNED_EN
  // Negative results reach down to -32, one past +31.
  assign mag   = {acc_hi_q, mplier_q};
  assign ovf_d = sign_q
    ? (mag > (2*N_BITS)'(32))
    : (mag > (2*N_BITS)'(31));
`endif

  // busy/done are registered from the current state,
  // so they trail the state register by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_hi_q <= '0;
      y        <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
`endif
    end else begin
      busy <= (state_q != S_IDLE);
      done <= (state_q == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          // busy still high in the done cycle.
          if (start && !busy) begin
            acc_hi_q <= '0;
            cnt_q    <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            a_q      <= a;
            b_q      <= b;
            state_q  <= S_NEG_A;
`else
            mcand_q  <= a;
            mplier_q <= b;
            state_q  <= S_ADD;
`endif
          end
        end
`ifdef MUL_SEQ_SIGNED_EN
        S_NEG_A: begin
          // 0-(-32) wraps to 6'b100000 = 32.
          mcand_q <= a_q[N_BITS-1] ? add_s : a_q;
          state_q <= S_NEG_B;
        end
        S_NEG_B: begin
          mplier_q <= b_q[N_BITS-1] ? add_s : b_q;
          sign_q   <= a_q[N_BITS-1] ^ b_q[N_BITS-1];
          state_q  <= S_ADD;
        end
        S_NEG_R: begin
          y       <= sign_q ? add_s : mplier_q;
          ovf     <= ovf_d;
          state_q <= S_DONE;
        end
`endif
        S_ADD: begin
          // Shift {c, acc_hi, mplier} right by one.
          acc_hi_q <= {add_c, add_s[N_BITS-1:1]};
          mplier_q <= {add_s[0], mplier_q[N_BITS-1:1]};
          if (cnt_q == MUL_LAST_ITER) begin
            cnt_q   <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            state_q <= S_NEG_R;
`else
            state_q <= S_DONE;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_DONE: begin
`ifndef MUL_SEQ_SIGNED_EN
          y   <= mplier_q;
          ovf <= |acc_hi_q;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb__mul_sequencer.sv
// Directed bench for _mul_sequencer, signed or
// unsigned build selected by MUL_SEQ_SIGNED_EN.
module tb__mul_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic [5:0] y;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef MUL_SEQ_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 7;
`endif

  always #5 clk = ~clk;

  _mul_sequencer #(
    .N_BITS(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .y    (y),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge (edge 0), then waits
  // up to 20 edges for done. lat = -1 on timeout.
  task automatic run_op(
    input  logic [5:0] ai,
    input  logic [5:0] bi,
    output int         lat,
    output int         nbusy
  );
    a     = ai;
    b     = bi;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    nbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (y !== 6'd0) begin
      errors++;
      $display("FAIL reset_y: got %b want 000000", y);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", done);
    end
  endtask

  task automatic test_product(
    input string      nm,
    input logic [5:0] ai,
    input logic [5:0] bi,
    input logic [5:0] ey,
    input logic       eovf
  );
    int lat;
    int nbusy;
    run_op(ai, bi, lat, nbusy);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s_lat: got %0d want %0d",
               nm, lat, LAT);
    end
    checks++;
    if (nbusy !== LAT) begin
      errors++;
      $display("FAIL %s_busy: got %0d want %0d",
               nm, nbusy, LAT);
    end
    checks++;
    if (y !== ey) begin
      errors++;
      $display("FAIL %s_y: got %b want %b",
               nm, y, ey);
    end
    checks++;
    if (ovf !== eovf) begin
      errors++;
      $display("FAIL %s_ovf: got %b want %b",
               nm, ovf, eovf);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: got %b want 0",
               nm, done);
    end
    tick();
  endtask

  // 8*8 = 64: low bits zero, overflows either build.
  task automatic test_start_held();
    int ndone = 0;
    int lat   = -1;
    int nchg  = 0;
    a     = 6'd8;
    b     = 6'd8;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        ndone++;
        lat   = k;
        start = 1'b0;
        break;
      end
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL held_lat: got %0d want %0d",
               lat, LAT);
    end
    checks++;
    if (y !== 6'b000000) begin
      errors++;
      $display("FAIL held_y: got %b want 000000", y);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL held_ovf: got %b want 1", ovf);
    end
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
      if (y !== 6'b000000 || ovf !== 1'b1) nchg++;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL held_ndone: got %0d want 1",
               ndone);
    end
    checks++;
    if (nchg !== 0) begin
      errors++;
      $display("FAIL held_stable: got %0d changes want 0",
               nchg);
    end
  endtask

  // Reset lands on edge 5 of a 3*5 operation.
  task automatic test_reset_mid();
    int ndone = 0;
    a     = 6'd3;
    b     = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy: got %b want 0", busy);
    end
    checks++;
    if (y !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_y: got %b want 000000", y);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ovf: got %b want 0", ovf);
    end
    if (done) ndone++;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rstmid_done: got %0d pulses want 0",
               ndone);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
`ifdef MUL_SEQ_SIGNED_EN
    test_product("pos", 6'd3, 6'd5,
                 6'b001111, 1'b0);
    test_product("neg", 6'b111100, 6'd6,
                 6'b101000, 1'b0);
    test_product("m32x1", 6'b100000, 6'd1,
                 6'b100000, 1'b0);
    test_product("m32xm1", 6'b100000, 6'b111111,
                 6'b100000, 1'b1);
    test_product("zero", 6'd0, 6'b111011,
                 6'b000000, 1'b0);
    test_start_held();
    test_reset_mid();
    test_product("after_rst", 6'b111101, 6'b111110,
                 6'b000110, 1'b0);
`else
    test_product("max", 6'd63, 6'd1,
                 6'b111111, 1'b0);
    test_product("ovf", 6'd9, 6'd8,
                 6'b001000, 1'b1);
    test_product("edge63", 6'd7, 6'd9,
                 6'b111111, 1'b0);
    test_product("zero", 6'd0, 6'd63,
                 6'b000000, 1'b0);
    test_start_held();
    test_reset_mid();
    test_product("after_rst", 6'd3, 6'd5,
                 6'b001111, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
